// File: rtl/mult_issue_queue.sv
// Operand FIFO plus issue controller for a sequential multiplier: queues A/B pairs,
// runs one start/done exchange at a time and holds each product on a valid/ready port.
module mult_issue_queue #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             a_i,
    input  logic [WIDTH-1:0]             b_i,
    output logic [WIDTH-1:0]             mul_a_o,
    output logic [WIDTH-1:0]             mul_b_o,
    output logic                         mul_start_o,
    input  logic                         mul_busy_i,
    input  logic                         mul_done_i,
    input  logic [2*WIDTH-1:0]           mul_result_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [2*WIDTH-1:0]           out_result_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ARM,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e              state_q;
    pair_t               fifo_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [TW-1:0]       tmo_q;
    logic [WIDTH-1:0]    mul_a_q, mul_b_q;
    logic                mul_start_q;
    logic                out_valid_q;
    logic [2*WIDTH-1:0]  out_result_q;
    logic                err_q;
    logic                push, pop;

    // Busy is informational only; sequencing relies on start/done.
    logic unused_busy;
    assign unused_busy = mul_busy_i;

    assign in_ready_o = (count_q != FULL_COUNT);
    assign push       = in_valid_i && in_ready_o;
    assign pop        = (state_q == S_IDLE) && (count_q != '0);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage array is not reset; occupancy and pointers alone define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{a: a_i, b: b_i};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tmo_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_start_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mul_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        mul_a_q     <= fifo_q[rd_ptr_q].a;
                        mul_b_q     <= fifo_q[rd_ptr_q].b;
                        mul_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: state_q <= S_ARM;
                // A done seen here belongs to the previous operation and is ignored.
                S_ARM:   state_q <= S_WAIT;
                S_WAIT: begin
                    if (mul_done_i) begin
                        out_result_q <= mul_result_i;
                        out_valid_q  <= 1'b1;
                        tmo_q        <= '0;
                        state_q      <= S_HOLD;
                    end else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;
    assign mul_start_o  = mul_start_q;
    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;
    assign count_o      = count_q;
    assign err_o        = err_q;

endmodule

// File: doc/mult_issue_queue.md
Name: mult_issue_queue

Overview:
Upstream/downstream companion to the sequential multiplier. Buffers operand pairs from a valid/ready producer in a small FIFO and issues them one at a time over the multiplier's start/busy/done handshake. Captures each product and presents it on a valid/ready output. Lets producers stream operands without tracking multiplier occupancy.

Parameters:
WIDTH, 16, operand width; product width is 2*WIDTH; must match the multiplier instance.
DEPTH, 4, operand FIFO entries; power of two, >= 2.
TIMEOUT, 255, max cycles spent in WAIT before an operation is abandoned; >= 1.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  reset; synchronous, active-high.
in_valid_i  in  1  operand pair valid.
in_ready_o  out  1  FIFO can accept; equals !full.
a_i  in  WIDTH  operand A.
b_i  in  WIDTH  operand B.
mul_a_o  out  WIDTH  operand A to multiplier.
mul_b_o  out  WIDTH  operand B to multiplier.
mul_start_o  out  1  one-cycle start pulse.
mul_busy_i  in  1  multiplier busy (status only; not used for control).
mul_done_i  in  1  multiplier done.
mul_result_i  in  2*WIDTH  multiplier product.
out_valid_o  out  1  product valid.
out_ready_i  in  1  consumer accepts product.
out_result_o  out  2*WIDTH  product.
count_o  out  $clog2(DEPTH+1)  FIFO occupancy.
err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i high at a clock edge): FIFO empty, count_o=0, in_ready_o=1, mul_start_o=0, mul_a_o/mul_b_o=0, out_valid_o=0, out_result_o=0, err_o=0, state IDLE, timeout counter=0.
- Reset asserted mid-operation: the in-flight product is discarded and done_i is ignored until the next ISSUE.
- Push: occurs when in_valid_i && in_ready_o. in_ready_o depends only on registered occupancy; there is no combinational pass-through when a pop happens in the same cycle.
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, ARM, WAIT, HOLD.
- IDLE -> ISSUE when FIFO is non-empty.
- ISSUE (1 cycle): mul_start_o=1. The FIFO head is loaded into mul_a_o/mul_b_o on entry and popped. -> ARM.
- ARM (1 cycle): mul_done_i is ignored, which masks a stale done from the previous operation. -> WAIT.
- WAIT: on mul_done_i=1, capture mul_result_i into out_result_o, set out_valid_o=1, -> HOLD.
- WAIT timeout: if the timeout counter reaches TIMEOUT first, set err_o=1, drop the operation, -> IDLE. The counter clears on leaving WAIT.
- HOLD: out_valid_o and out_result_o are held stable. On out_ready_i=1, out_valid_o=0 next cycle, -> IDLE.
- mul_a_o/mul_b_o are stable from ISSUE until the next ISSUE.
- Latency: a pair pushed at edge N into an empty FIFO in IDLE gives IDLE->ISSUE at N+1, so mul_start_o is high in cycle N+1. out_valid_o rises the edge after done_i is sampled in WAIT.
- Throughput: one product per (multiplier latency + 4) cycles when the consumer is always ready.
- Ordering: products leave in push order. Nothing is dropped except on timeout.
- Backpressure: a stalled consumer holds HOLD. The FIFO continues filling to DEPTH, then in_ready_o=0.
- err_o is cleared only by reset.

Test Plan:
- Reset check: assert rst_i 3 cycles -> all outputs at reset values; in_ready_o=1, count_o=0.
- Single op: push A=16'h0003, B=16'h0005 into an idle block -> mul_start_o pulses exactly 1 cycle, one cycle after the push; out_result_o=32'h0000000F with out_valid_o=1; cleared one cycle after out_ready_i.
- Stream 20 random pairs back-to-back, out_ready_i=1 -> 20 products in order, each equal to A*B; no extra start pulses.
- Full/backpressure: DEPTH=4, out_ready_i=0, push 6 pairs -> first product held in HOLD, count_o=4, in_ready_o=0; release out_ready_i -> all 5 remaining products drained in order.
- Max values: A=B=16'hFFFF -> out_result_o=32'hFFFE0001.
- Timeout: model never asserts done, TIMEOUT=8 -> err_o=1 at cycle 8 of WAIT; next queued pair is issued normally.
- Reset mid-WAIT: a late mul_done_i arrives after reset -> ignored, out_valid_o stays 0.
